mips32_trace_buffer: RTL and testbench
======================================

Name: mips32_trace_buffer

Overview:
- Synthesizable retirement-trace capture unit for the MIPS32 core. It is the on-chip successor to the bench's $monitor/$display tracing.
- Records {PC, instruction, ALU result, reg_write, timestamp} per retired instruction into a parametrised circular buffer.
- Supports PC-match or forced trigger, a programmable post-trigger window, and oldest-first readback.
- Sits beside mips32_processor and taps pc_out, instruction_out, alu_result_out and reg_write.

Parameters:
- DATA_W, 32, width of PC, instruction and ALU result fields.
- DEPTH, 16, buffer entries; power of two, >= 4.
- TS_W, 16, timestamp width (cycles since arm).
- PTR_W, $clog2(DEPTH), derived pointer width; not overridden.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset (0 = reset).
- arm  in  1  one-cycle pulse: clear buffer, start capture.
- valid_in  in  1  instruction retires this cycle.
- pc_in  in  DATA_W  retiring PC.
- instruction_in  in  DATA_W  retiring instruction.
- alu_result_in  in  DATA_W  ALU result.
- reg_write_in  in  1  register-file write enable.
- trig_pc_en  in  1  enable PC-match trigger.
- trig_pc  in  DATA_W  trigger PC value.
- force_trig  in  1  immediate trigger.
- post_len  in  PTR_W+1  entries to capture after the trigger entry.
- rd_en  in  1  pop one entry (DONE state only).
- rd_valid  out  1  read data valid (one-cycle pulse).
- rd_pc  out  DATA_W  popped PC.
- rd_inst  out  DATA_W  popped instruction.
- rd_alu  out  DATA_W  popped ALU result.
- rd_regwrite  out  1  popped reg_write.
- rd_ts  out  TS_W  popped timestamp.
- state  out  2  00 IDLE, 01 PRE, 10 POST, 11 DONE.
- count  out  PTR_W+1  valid entries held, 0..DEPTH.

Behaviour:
- Reset (reset=0, async): state=IDLE, count=0, wr_ptr=rd_ptr=0, ts=0, rd_valid=0. All rd_* data outputs are 0. Buffer RAM is not cleared.
- ts counter: cleared by arm, +1 every cycle in PRE/POST, wraps modulo 2^TS_W, holds in IDLE/DONE.
- Capture: in PRE or POST, valid_in=1 writes the entry at wr_ptr, stamped with the current ts. wr_ptr increments and wraps at DEPTH. count increments, saturating at DEPTH; when full, the oldest entry is overwritten (the read origin advances implicitly).
- Trigger: asserted in PRE when force_trig=1, or when valid_in=1 && trig_pc_en=1 && pc_in==trig_pc.
  - A force_trig with valid_in=0 still triggers.
  - The triggering retirement itself is written and is the trigger entry.
- Window length: remaining is loaded with min(post_len, DEPTH-1) on trigger, so the trigger entry is never overwritten.
- Transitions:
  - IDLE->PRE on arm.
  - PRE->POST on trigger when clamped post_len>0.
  - PRE->DONE on trigger when post_len=0.
  - POST: each valid_in write decrements remaining; the write that brings remaining to 0 moves to DONE in the same edge (the entry is stored).
  - DONE: holds until arm.
- Triggers in POST or DONE are ignored.
- arm priority: arm in any state (including mid-POST or mid-readback) clears count, pointers and ts and enters PRE. arm beats a simultaneous trigger, valid_in and rd_en; nothing is written or popped that cycle.
- Readback: only in DONE.
  - rd_en=1 with count>0: the entry at the oldest position (wr_ptr-count mod DEPTH) appears on rd_* the next cycle with rd_valid=1, and count decrements.
  - rd_en with count=0, or outside DONE: ignored, rd_valid=0, rd_* hold their previous value.
  - Back-to-back rd_en is allowed, giving one entry per cycle.
- Writes never occur in IDLE/DONE; valid_in is ignored there.

Test Plan:
- Reset mid-POST: arm, 5 retirements, trigger, assert reset=0 asynchronously between edges -> state=00, count=0, rd_valid=0 immediately, without waiting for a clock.
- Basic PC trigger: DEPTH=16, arm, retire PCs 0x00,0x04,...,0x3C (16 entries), trig_pc=0x20, post_len=3 -> DONE after the write of PC 0x2C; count=12; readback gives PCs 0x00..0x2C in order with ts strictly increasing.
- Wrap/overwrite: arm, 40 retirements PC=4*i with no trigger, then force_trig with valid_in=0, post_len=0 -> DONE, count=16, first read rd_pc=0x60, last 0x9C.
- Clamp: post_len=16 (>DEPTH-1) -> exactly 15 entries after the trigger; trigger entry is the first read, count=16.
- Priority: arm and PC-match in the same cycle -> state=PRE, count=0; a following match triggers normally.
- Readback underflow: in DONE, pop all 4 entries with back-to-back rd_en, then 2 extra rd_en -> exactly 4 rd_valid pulses; count=0; rd_pc holds the last value.

Source files
------------

// File: rtl/mips32_trace_buffer.sv
// Retirement-trace capture for the MIPS32 core: circular buffer of retired
// instructions with PC/forced trigger, post-trigger window and oldest-first readback.
module mips32_trace_buffer #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 16,
    parameter int TS_W   = 16,
    parameter int PTR_W  = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              arm,
    input  logic              valid_in,
    input  logic [DATA_W-1:0] pc_in,
    input  logic [DATA_W-1:0] instruction_in,
    input  logic [DATA_W-1:0] alu_result_in,
    input  logic              reg_write_in,
    input  logic              trig_pc_en,
    input  logic [DATA_W-1:0] trig_pc,
    input  logic              force_trig,
    input  logic [PTR_W:0]    post_len,
    input  logic              rd_en,
    output logic              rd_valid,
    output logic [DATA_W-1:0] rd_pc,
    output logic [DATA_W-1:0] rd_inst,
    output logic [DATA_W-1:0] rd_alu,
    output logic              rd_regwrite,
    output logic [TS_W-1:0]   rd_ts,
    output logic [1:0]        state,
    output logic [PTR_W:0]    count
);
    localparam int ENTRY_W = 3 * DATA_W + 1 + TS_W;
    localparam logic [PTR_W:0] FULL = (PTR_W + 1)'(DEPTH);
    localparam logic [PTR_W:0] LAST = (PTR_W + 1)'(DEPTH - 1);
    localparam logic [PTR_W:0] ONE  = (PTR_W + 1)'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_PRE  = 2'b01,
        S_POST = 2'b10,
        S_DONE = 2'b11
    } state_t;

    state_t              cur, nxt;
    logic [ENTRY_W-1:0]  mem [DEPTH];
    logic [PTR_W-1:0]    wr_ptr;
    logic [PTR_W-1:0]    oldest;
    logic [PTR_W:0]      count_q;
    logic [PTR_W:0]      remaining;
    logic [PTR_W:0]      clamp_len;
    logic [TS_W-1:0]     ts;
    logic                capturing, trig, do_write, do_read;

    assign state = cur;
    assign count = count_q;

    always_comb begin
        capturing = (cur == S_PRE) || (cur == S_POST);
        trig      = (cur == S_PRE) &&
                    (force_trig || (valid_in && trig_pc_en && (pc_in == trig_pc)));
        do_write  = !arm && capturing && valid_in;
        do_read   = !arm && (cur == S_DONE) && rd_en && (count_q != '0);
        // Window capped at DEPTH-1 so the trigger entry always survives.
        clamp_len = (post_len > LAST) ? LAST : post_len;
        // With count==DEPTH the low bits are zero, so oldest == wr_ptr.
        oldest    = wr_ptr - count_q[PTR_W-1:0];
    end

    always_comb begin
        nxt = cur;
        if (arm) begin
            nxt = S_PRE;
        end else begin
            case (cur)
                S_PRE:   if (trig) nxt = (clamp_len != '0) ? S_POST : S_DONE;
                S_POST:  if (valid_in && (remaining == ONE)) nxt = S_DONE;
                default: nxt = cur;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_write)
            mem[wr_ptr] <= {pc_in, instruction_in, alu_result_in, reg_write_in, ts};
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cur         <= S_IDLE;
            wr_ptr      <= '0;
            count_q     <= '0;
            remaining   <= '0;
            ts          <= '0;
            rd_valid    <= 1'b0;
            rd_pc       <= '0;
            rd_inst     <= '0;
            rd_alu      <= '0;
            rd_regwrite <= 1'b0;
            rd_ts       <= '0;
        end else begin
            cur      <= nxt;
            rd_valid <= do_read;
            if (arm) begin
                wr_ptr    <= '0;
                count_q   <= '0;
                remaining <= '0;
                ts        <= '0;
            end else begin
                if (capturing)
                    ts <= ts + 1'b1;
                if (do_write) begin
                    wr_ptr <= wr_ptr + 1'b1;
                    if (count_q != FULL)
                        count_q <= count_q + 1'b1;
                end
                if (trig)
                    remaining <= clamp_len;
                else if ((cur == S_POST) && valid_in)
                    remaining <= remaining - 1'b1;
                if (do_read) begin
                    count_q <= count_q - 1'b1;
                    {rd_pc, rd_inst, rd_alu, rd_regwrite, rd_ts} <= mem[oldest];
                end
            end
        end
    end
endmodule

// File: tb/tb_mips32_trace_buffer.sv
// Bench for mips32_trace_buffer: directed scenarios plus randomized traffic,
// compared every cycle against a queue-based model of the trace buffer.
module tb_mips32_trace_buffer;
    localparam int DATA_W = 32;
    localparam int DEPTH  = 16;
    localparam int TS_W   = 16;
    localparam int PTR_W  = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic              arm, valid_in, reg_write_in, trig_pc_en, force_trig, rd_en;
    logic [DATA_W-1:0] pc_in, instruction_in, alu_result_in, trig_pc;
    logic [PTR_W:0]    post_len;
    logic              rd_valid, rd_regwrite;
    logic [DATA_W-1:0] rd_pc, rd_inst, rd_alu;
    logic [TS_W-1:0]   rd_ts;
    logic [1:0]        state;
    logic [PTR_W:0]    count;

    mips32_trace_buffer #(.DATA_W(DATA_W), .DEPTH(DEPTH), .TS_W(TS_W)) dut (
        .clk(clk), .reset(reset), .arm(arm), .valid_in(valid_in),
        .pc_in(pc_in), .instruction_in(instruction_in), .alu_result_in(alu_result_in),
        .reg_write_in(reg_write_in), .trig_pc_en(trig_pc_en), .trig_pc(trig_pc),
        .force_trig(force_trig), .post_len(post_len), .rd_en(rd_en),
        .rd_valid(rd_valid), .rd_pc(rd_pc), .rd_inst(rd_inst), .rd_alu(rd_alu),
        .rd_regwrite(rd_regwrite), .rd_ts(rd_ts), .state(state), .count(count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
        logic [31:0] alu;
        logic        rw;
        int          ts;
    } entry_t;

    // Reference model: the buffer is a queue of what software would see on readback.
    entry_t m_q[$];
    entry_t m_rd;
    int     m_state;
    int     m_ts;
    int     m_rem;
    bit     m_rdv;

    int tests  = 0;
    int failed = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            failed++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_rd    = '{pc: 0, inst: 0, alu: 0, rw: 0, ts: 0};
        m_state = 0;
        m_ts    = 0;
        m_rem   = 0;
        m_rdv   = 0;
    endtask

    task automatic model_step();
        int  old;
        bit  hit;
        int  win;
        entry_t e;
        old   = m_state;
        m_rdv = 0;
        if (arm) begin
            m_q.delete();
            m_ts    = 0;
            m_rem   = 0;
            m_state = 1;
        end else if (old == 1 || old == 2) begin
            hit = (old == 1) && (force_trig || (valid_in && trig_pc_en && pc_in == trig_pc));
            if (valid_in) begin
                e = '{pc: pc_in, inst: instruction_in, alu: alu_result_in,
                      rw: reg_write_in, ts: m_ts};
                m_q.push_back(e);
                if (m_q.size() > DEPTH) void'(m_q.pop_front());
            end
            if (hit) begin
                win = (int'(post_len) > DEPTH - 1) ? DEPTH - 1 : int'(post_len);
                if (win == 0) m_state = 3;
                else begin
                    m_state = 2;
                    m_rem   = win;
                end
            end else if (old == 2 && valid_in) begin
                m_rem--;
                if (m_rem == 0) m_state = 3;
            end
            m_ts = (m_ts + 1) % (1 << TS_W);
        end else if (old == 3 && rd_en && m_q.size() > 0) begin
            m_rd  = m_q.pop_front();
            m_rdv = 1;
        end
    endtask

    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
        check("state", 64'(state), 64'(m_state));
        check("count", 64'(count), 64'(m_q.size()));
        check("rd_valid", 64'(rd_valid), 64'(m_rdv));
        check("rd_pc", 64'(rd_pc), 64'(m_rd.pc));
        check("rd_inst", 64'(rd_inst), 64'(m_rd.inst));
        check("rd_alu", 64'(rd_alu), 64'(m_rd.alu));
        check("rd_regwrite", 64'(rd_regwrite), 64'(m_rd.rw));
        check("rd_ts", 64'(rd_ts), 64'(m_rd.ts));
    endtask

    task automatic idle_inputs();
        arm = 0; valid_in = 0; force_trig = 0; rd_en = 0; reg_write_in = 0;
        pc_in = 0; instruction_in = 0; alu_result_in = 0;
    endtask

    task automatic do_arm();
        arm = 1;
        cycle();
        arm = 0;
    endtask

    task automatic retire(input logic [31:0] pc);
        valid_in       = 1;
        pc_in          = pc;
        instruction_in = $urandom;
        alu_result_in  = $urandom;
        reg_write_in   = 1'($urandom_range(0, 1));
        cycle();
        valid_in = 0;
    endtask

    task automatic pop(input int n);
        rd_en = 1;
        repeat (n) cycle();
        rd_en = 0;
    endtask

    initial begin
        logic [TS_W-1:0] prev_ts;
        reset = 0;
        trig_pc_en = 0; trig_pc = 0; post_len = 0;
        idle_inputs();
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("reset_state", 64'(state), 64'd0);
        check("reset_count", 64'(count), 64'd0);
        check("reset_rd_valid", 64'(rd_valid), 64'd0);
        check("reset_rd_pc", 64'(rd_pc), 64'd0);
        @(negedge clk);
        reset = 1;

        // Asynchronous reset in the middle of the post-trigger window.
        do_arm();
        trig_pc_en = 1; trig_pc = 32'h100; post_len = 5;
        for (int i = 0; i < 5; i++) retire(32'(4 * i));
        retire(32'h100);
        retire(32'h104);
        check("mid_post_state", 64'(state), 64'd2);
        #3;
        reset = 0;
        #1;
        check("async_rst_state", 64'(state), 64'd0);
        check("async_rst_count", 64'(count), 64'd0);
        check("async_rst_rd_valid", 64'(rd_valid), 64'd0);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        reset = 1;

        // Basic PC trigger with a 3-entry window.
        do_arm();
        trig_pc_en = 1; trig_pc = 32'h20; post_len = 3;
        for (int i = 0; i < 16; i++) retire(32'(4 * i));
        check("basic_state", 64'(state), 64'd3);
        check("basic_count", 64'(count), 64'd12);
        prev_ts = '0;
        rd_en = 1;
        for (int i = 0; i < 12; i++) begin
            cycle();
            check("basic_rd_pc", 64'(rd_pc), 64'(4 * i));
            if (i > 0) check("basic_ts_incr", 64'(rd_ts > prev_ts), 64'd1);
            prev_ts = rd_ts;
        end
        rd_en = 0;

        // Overwrite: 40 retirements, forced trigger without a retirement.
        trig_pc_en = 0; post_len = 0;
        do_arm();
        for (int i = 0; i < 40; i++) retire(32'(4 * i));
        force_trig = 1;
        cycle();
        force_trig = 0;
        check("wrap_state", 64'(state), 64'd3);
        check("wrap_count", 64'(count), 64'd16);
        pop(1);
        check("wrap_first_pc", 64'(rd_pc), 64'h60);
        pop(15);
        check("wrap_last_pc", 64'(rd_pc), 64'h9c);

        // Window clamp: post_len beyond DEPTH-1.
        do_arm();
        trig_pc_en = 1; trig_pc = 32'h500; post_len = 16;
        for (int i = 0; i < 5; i++) retire(32'(4 * i));
        retire(32'h500);
        for (int i = 0; i < 14; i++) retire(32'h600 + 32'(4 * i));
        check("clamp_still_post", 64'(state), 64'd2);
        retire(32'h700);
        check("clamp_done", 64'(state), 64'd3);
        check("clamp_count", 64'(count), 64'd16);
        retire(32'h800);
        pop(1);
        check("clamp_first_pc", 64'(rd_pc), 64'h500);

        // arm beats a simultaneous PC match.
        trig_pc = 32'h40; post_len = 0;
        arm = 1; valid_in = 1; pc_in = 32'h40;
        cycle();
        arm = 0; valid_in = 0;
        check("prio_state", 64'(state), 64'd1);
        check("prio_count", 64'(count), 64'd0);
        retire(32'h40);
        check("prio_retrig_state", 64'(state), 64'd3);

        // Underflow: 4 entries, 6 back-to-back pops.
        do_arm();
        trig_pc = 32'h80; post_len = 3;
        retire(32'h80);
        for (int i = 1; i < 4; i++) retire(32'h80 + 32'(4 * i));
        check("uf_count", 64'(count), 64'd4);
        rd_en = 1;
        for (int i = 0; i < 6; i++) begin
            cycle();
            check("uf_rd_valid", 64'(rd_valid), (i < 4) ? 64'd1 : 64'd0);
        end
        rd_en = 0;
        check("uf_count_end", 64'(count), 64'd0);
        check("uf_rd_pc_hold", 64'(rd_pc), 64'h8c);

        // Randomized traffic.
        for (int r = 0; r < 25; r++) begin
            post_len   = 5'($urandom_range(0, 16));
            trig_pc    = 32'(4 * $urandom_range(0, 15));
            trig_pc_en = 1'($urandom_range(0, 1));
            do_arm();
            for (int c = 0; c < 50; c++) begin
                valid_in       = ($urandom_range(0, 3) != 0);
                pc_in          = 32'(4 * $urandom_range(0, 15));
                instruction_in = $urandom;
                alu_result_in  = $urandom;
                reg_write_in   = 1'($urandom_range(0, 1));
                force_trig     = ($urandom_range(0, 19) == 0);
                rd_en          = 1'($urandom_range(0, 1));
                arm            = ($urandom_range(0, 99) == 0);
                cycle();
            end
            idle_inputs();
            for (int c = 0; c < 20; c++) begin
                rd_en = 1'($urandom_range(0, 3) != 0);
                valid_in = 1'($urandom_range(0, 1));
                cycle();
            end
            idle_inputs();
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
